// File: rtl/exm_lane_sync.sv
// N-lane completion synchroniser: parks early-finishing lane results and releases the whole issue group to WB in one transfer.
// Optional wait-cycle performance counter enabled by defining EXM_LANE_SYNC_PERF_EN.
module exm_lane_sync #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LANES-1:0]         lane_valid,
    input  logic [LANES-1:0]         lane_ok,
    input  logic [LANES*DATA_W-1:0]  lane_result,
    input  logic                     flush,
    input  logic                     ws_ready,
    output logic                     in_ready,
    output logic [LANES-1:0]         lane_parked,
    output logic                     out_valid,
    output logic [LANES-1:0]         out_mask,
    output logic [LANES*DATA_W-1:0]  out_result
`ifdef EXM_LANE_SYNC_PERF_EN
    ,
    input  logic                     perf_clr,
    output logic [31:0]              perf_wait_cycles
`endif
);

    logic [LANES-1:0]        r_parked;
    logic [DATA_W-1:0]       r_park [LANES];
    logic                    r_out_valid;
    logic [LANES-1:0]        r_out_mask;
    logic [LANES*DATA_W-1:0] r_out_result;

    logic [LANES-1:0]        w_done;
    logic                    w_fire;
    logic                    w_out_accept;
    logic                    w_any_valid;
    logic                    w_go;
    logic [LANES-1:0]        w_park_en;
    logic [LANES*DATA_W-1:0] w_sel;

    assign w_done       = ~lane_valid | lane_ok | r_parked;
    assign w_fire       = &w_done;
    assign w_out_accept = ~r_out_valid | ws_ready;
    assign w_any_valid  = |lane_valid;
    assign w_go         = w_fire & w_out_accept & w_any_valid & ~flush;
    assign w_park_en    = (w_go | flush) ? '0 : (lane_valid & lane_ok & ~r_parked);

    // Parked data always wins over the live bus, even if lane_ok is still high.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sel[i*DATA_W +: DATA_W] = r_parked[i] ? r_park[i] : lane_result[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_parked     <= '0;
            r_out_valid  <= 1'b0;
            r_out_mask   <= '0;
            r_out_result <= '0;
        end else if (flush) begin
            r_parked    <= '0;
            r_out_valid <= 1'b0;
        end else if (w_go) begin
            r_parked     <= '0;
            r_out_valid  <= 1'b1;
            r_out_mask   <= lane_valid;
            r_out_result <= w_sel;
        end else begin
            r_parked <= r_parked | w_park_en;
            if (ws_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Captured results need no reset: they are only visible while the parked bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_park_en[i]) begin
                r_park[i] <= lane_result[i*DATA_W +: DATA_W];
            end
        end
    end

    assign in_ready    = reset & (w_go | flush | (w_fire & w_out_accept & ~w_any_valid));
    assign lane_parked = reset ? r_parked : '0;
    assign out_valid   = r_out_valid;
    assign out_mask    = r_out_mask;
    assign out_result  = r_out_result;

`ifdef EXM_LANE_SYNC_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (!reset || perf_clr) begin
            r_perf <= '0;
        end else if (w_any_valid && !w_go && !flush) begin
            r_perf <= sat_inc(r_perf);
        end
    end

    assign perf_wait_cycles = r_perf;
`endif

endmodule

// File: tb/tb_exm_lane_sync.sv
// Directed table-driven bench for exm_lane_sync (LANES=2, DATA_W=32); perf checks built with EXM_LANE_SYNC_PERF_EN.
module tb_exm_lane_sync;

    logic        clk;
    logic        reset;
    logic [1:0]  lane_valid;
    logic [1:0]  lane_ok;
    logic [63:0] lane_result;
    logic        flush;
    logic        ws_ready;
    logic        in_ready;
    logic [1:0]  lane_parked;
    logic        out_valid;
    logic [1:0]  out_mask;
    logic [63:0] out_result;
`ifdef EXM_LANE_SYNC_PERF_EN
    logic        perf_clr;
    logic [31:0] perf_wait_cycles;
`endif

    exm_lane_sync #(.LANES(2), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .lane_valid  (lane_valid),
        .lane_ok     (lane_ok),
        .lane_result (lane_result),
        .flush       (flush),
        .ws_ready    (ws_ready),
        .in_ready    (in_ready),
        .lane_parked (lane_parked),
        .out_valid   (out_valid),
        .out_mask    (out_mask),
        .out_result  (out_result)
`ifdef EXM_LANE_SYNC_PERF_EN
        ,
        .perf_clr         (perf_clr),
        .perf_wait_cycles (perf_wait_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream must not drop a lane that is still parked.
    always @(posedge clk) begin
        if (reset && |(lane_parked & ~lane_valid)) begin
            $error("protocol: lane_valid dropped while parked (%b/%b)", lane_valid, lane_parked);
        end
    end

    typedef struct packed {
        logic        rst_n;
        logic [1:0]  lv;
        logic [1:0]  ok;
        logic [31:0] r1;
        logic [31:0] r0;
        logic        fl;
        logic        wr;
        logic        e_inr;
        logic        e_ov;
        logic [1:0]  e_mask;
        logic [63:0] e_res;
        logic [1:0]  e_park;
    } vec_t;

    vec_t vq[$];
    int   n_vec;
    int   n_chk;
    int   n_fail;

    function automatic vec_t mk(input logic rst_n, input logic [1:0] lv, input logic [1:0] ok,
                                input logic [31:0] r1, input logic [31:0] r0,
                                input logic fl, input logic wr, input logic e_inr, input logic e_ov,
                                input logic [1:0] e_mask, input logic [31:0] e1, input logic [31:0] e0,
                                input logic [1:0] e_park);
        vec_t v;
        v.rst_n = rst_n; v.lv = lv; v.ok = ok; v.r1 = r1; v.r0 = r0;
        v.fl = fl; v.wr = wr; v.e_inr = e_inr; v.e_ov = e_ov;
        v.e_mask = e_mask; v.e_res = {e1, e0}; v.e_park = e_park;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        @(negedge clk);
        reset       = v.rst_n;
        lane_valid  = v.lv;
        lane_ok     = v.ok;
        lane_result = {v.r1, v.r0};
        flush       = v.fl;
        ws_ready    = v.wr;
        #1;
        chk("in_ready", idx, {63'd0, in_ready}, {63'd0, v.e_inr});
        @(posedge clk);
        #1;
        chk("out_valid",   idx, {63'd0, out_valid},   {63'd0, v.e_ov});
        chk("out_mask",    idx, {62'd0, out_mask},    {62'd0, v.e_mask});
        chk("out_result",  idx, out_result,           v.e_res);
        chk("lane_parked", idx, {62'd0, lane_parked}, {62'd0, v.e_park});
        n_vec++;
    endtask

    initial begin
        n_vec = 0; n_chk = 0; n_fail = 0;
        reset = 1'b0; lane_valid = '0; lane_ok = '0; lane_result = '0;
        flush = 1'b0; ws_ready = 1'b1;
`ifdef EXM_LANE_SYNC_PERF_EN
        perf_clr = 1'b0;
`endif
        //            rst   lv     ok     r1     r0     fl wr  inr ov mask   e1     e0     park
        // reset
        vq.push_back(mk(0, 2'b00, 2'b00, 'h0,   'h0,   0, 1,  0, 0, 2'b00, 'h0,   'h0,   2'b00));
        vq.push_back(mk(0, 2'b00, 2'b00, 'h0,   'h0,   0, 1,  0, 0, 2'b00, 'h0,   'h0,   2'b00));
        // both lanes done in issue cycle; then an empty group
        vq.push_back(mk(1, 2'b11, 2'b11, 'h22,  'h11,  0, 1,  1, 1, 2'b11, 'h22,  'h11,  2'b00));
        vq.push_back(mk(1, 2'b00, 2'b00, 'h0,   'h0,   0, 1,  1, 0, 2'b11, 'h22,  'h11,  2'b00));
        // lane0 early, lane1 three cycles later, lane0 bus garbage meanwhile
        vq.push_back(mk(1, 2'b11, 2'b01, 'h1234,'hAAAA,0, 1,  0, 0, 2'b11, 'h22,  'h11,  2'b01));
        vq.push_back(mk(1, 2'b11, 2'b00, 'h5555,'hDEAD,0, 1,  0, 0, 2'b11, 'h22,  'h11,  2'b01));
        vq.push_back(mk(1, 2'b11, 2'b00, 'h5555,'h0BAD,0, 1,  0, 0, 2'b11, 'h22,  'h11,  2'b01));
        vq.push_back(mk(1, 2'b11, 2'b10, 'hBBBB,'hFFFF,0, 1,  1, 1, 2'b11, 'hBBBB,'hAAAA, 2'b00));
        // backpressure: both park, old output held, then release
        vq.push_back(mk(1, 2'b11, 2'b11, 'h44,  'h33,  0, 0,  0, 1, 2'b11, 'hBBBB,'hAAAA, 2'b11));
        vq.push_back(mk(1, 2'b11, 2'b11, 'h77,  'h66,  0, 0,  0, 1, 2'b11, 'hBBBB,'hAAAA, 2'b11));
        vq.push_back(mk(1, 2'b11, 2'b00, 'h0,   'h0,   0, 1,  1, 1, 2'b11, 'h44,  'h33,  2'b00));
        // lane0 empty; then empty group drains output
        vq.push_back(mk(1, 2'b10, 2'b10, 'h99,  'h0,   0, 1,  1, 1, 2'b10, 'h99,  'h0,   2'b00));
        vq.push_back(mk(1, 2'b00, 2'b00, 'h0,   'h0,   0, 1,  1, 0, 2'b10, 'h99,  'h0,   2'b00));
        // flush while lane0 parked
        vq.push_back(mk(1, 2'b11, 2'b01, 'h0,   'hC0,  0, 1,  0, 0, 2'b10, 'h99,  'h0,   2'b01));
        vq.push_back(mk(1, 2'b11, 2'b00, 'h0,   'h0,   0, 1,  0, 0, 2'b10, 'h99,  'h0,   2'b01));
        vq.push_back(mk(1, 2'b11, 2'b00, 'h0,   'h0,   1, 1,  1, 0, 2'b10, 'h99,  'h0,   2'b00));
        vq.push_back(mk(1, 2'b00, 2'b00, 'h0,   'h0,   0, 1,  1, 0, 2'b10, 'h99,  'h0,   2'b00));
        // reset while lane1 parked and out_valid=1, then a fresh group
        vq.push_back(mk(1, 2'b11, 2'b11, 'hD1,  'hD0,  0, 1,  1, 1, 2'b11, 'hD1,  'hD0,  2'b00));
        vq.push_back(mk(1, 2'b11, 2'b10, 'hE1,  'h0,   0, 0,  0, 1, 2'b11, 'hD1,  'hD0,  2'b10));
        vq.push_back(mk(0, 2'b11, 2'b00, 'h0,   'h0,   0, 0,  0, 0, 2'b00, 'h0,   'h0,   2'b00));
        vq.push_back(mk(1, 2'b11, 2'b11, 'hF1,  'hF0,  0, 1,  1, 1, 2'b11, 'hF1,  'hF0,  2'b00));

        for (int i = 0; i < vq.size(); i++) begin
            run(vq[i], i);
        end

        // back-to-back transfers: ws_ready with out_valid=1 loads the next group on the same edge
        run(mk(1, 2'b11, 2'b11, 'hA2, 'hA1, 0, 1, 1, 1, 2'b11, 'hA2, 'hA1, 2'b00), 100);
        run(mk(1, 2'b11, 2'b11, 'hB2, 'hB1, 0, 1, 1, 1, 2'b11, 'hB2, 'hB1, 2'b00), 101);
        // live result arriving in the go cycle is not parked
        run(mk(1, 2'b11, 2'b01, 'h0,  'hC1, 0, 1, 0, 0, 2'b11, 'hB2, 'hB1, 2'b01), 102);
        run(mk(1, 2'b11, 2'b11, 'hC2, 'hEE, 0, 1, 1, 1, 2'b11, 'hC2, 'hC1, 2'b00), 103);
        run(mk(1, 2'b00, 2'b00, 'h0,  'h0,  0, 1, 1, 0, 2'b11, 'hC2, 'hC1, 2'b00), 104);

`ifdef EXM_LANE_SYNC_PERF_EN
        // counter: clear, wait three cycles for lane1, then clear must beat increment
        @(negedge clk); perf_clr = 1'b1;
        @(posedge clk); #1;
        chk("perf_clr", 200, {32'd0, perf_wait_cycles}, 64'd0);
        @(negedge clk); perf_clr = 1'b0;
        run(mk(1, 2'b11, 2'b01, 'h0,    'hAAAA, 0, 1, 0, 0, 2'b11, 'hC2,   'hC1,   2'b01), 201);
        run(mk(1, 2'b11, 2'b00, 'h0,    'h0,    0, 1, 0, 0, 2'b11, 'hC2,   'hC1,   2'b01), 202);
        run(mk(1, 2'b11, 2'b00, 'h0,    'h0,    0, 1, 0, 0, 2'b11, 'hC2,   'hC1,   2'b01), 203);
        run(mk(1, 2'b11, 2'b10, 'hBBBB, 'h0,    0, 1, 1, 1, 2'b11, 'hBBBB, 'hAAAA, 2'b00), 204);
        chk("perf_wait", 205, {32'd0, perf_wait_cycles}, 64'd3);
        @(negedge clk);
        lane_valid = 2'b11; lane_ok = 2'b00; perf_clr = 1'b1;
        @(posedge clk); #1;
        chk("perf_clr_wins", 206, {32'd0, perf_wait_cycles}, 64'd0);
        @(negedge clk); perf_clr = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        chk("perf_flush", 207, {32'd0, perf_wait_cycles}, 64'd0);
        @(negedge clk); flush = 1'b0; lane_valid = 2'b00;
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/exm_lane_sync.md
Name: exm_lane_sync

Overview:
- N-lane completion synchroniser between the lanes of the execute/memory stage and writeback.
- Each lane finishes its instruction in a variable number of cycles (cache, divider, multiplier).
- A lane that finishes early has its result parked until every valid lane of the issue group is done. The whole group is then registered toward WB in one transfer, with ws_ready backpressure and flush.
- It generalises the two-lane wait-me/wait-another handshake to LANES lanes of DATA_W-bit results.

Parameters:
LANES, 2, number of parallel execute lanes in an issue group (1..8)
DATA_W, 32, per-lane result width in bits (final result plus any sideband the lane packs)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous active-low reset (0 = reset, sampled on rising clk)
lane_valid  input  LANES  lane i holds a live instruction of the current group
lane_ok  input  LANES  lane i result valid this cycle (combinational from lane)
lane_result  input  LANES*DATA_W  lane i result at bits [i*DATA_W +: DATA_W]
flush  input  1  synchronous flush of the current group and the output register
ws_ready  input  1  WB accepts out_* this cycle
in_ready  output  1  current group consumed; upstream may present the next group
lane_parked  output  LANES  lane i result captured; lane may stop driving lane_ok
out_valid  output  1  out_* holds a group for WB
out_mask  output  LANES  which lanes of the emitted group were valid
out_result  output  LANES*DATA_W  emitted per-lane results

Behaviour:
- Per-lane state, one bit each: IDLE (0) or PARKED (1). A parked lane also holds its captured result in a DATA_W register park_r[i].
- done[i] = !lane_valid[i] | lane_ok[i] | parked[i].
- fire = &done.
- out_accept = !out_valid | ws_ready.
- go = fire & out_accept & (|lane_valid) & !flush.
- Result select per lane: parked[i] ? park_r[i] : lane_result[i]. Parked data always wins, even if lane_ok is still high.
- Parking: when lane_valid[i] & lane_ok[i] & !parked[i] & !go & !flush, then parked[i] <= 1 and park_r[i] <= lane_result[i].
- On go:
  - out_valid <= 1, out_mask <= lane_valid, out_result <= selected results.
  - All parked bits clear.
- When not go and ws_ready: out_valid <= 0. out_mask and out_result hold their values.
- When not go and !ws_ready: out_* hold unchanged.
- in_ready is combinational: go | flush | (fire & out_accept & ~|lane_valid).
  - An empty group is consumed without emitting anything.
- Latency:
  - A group whose lanes all assert lane_ok in the issue cycle appears on out_valid the next cycle (1 cycle).
  - Otherwise it appears 1 cycle after the last lane completes, provided out_accept.
- Backpressure: with out_valid=1 and ws_ready=0, go=0. Completing lanes park, and the group fires on the first cycle ws_ready=1.
- Upstream protocol: lane_valid and the group contents stay stable until in_ready=1. A lane deasserting lane_valid while parked is a protocol violation; the bench asserts on it.
- Flush (priority over go and parking): all parked bits <= 0, out_valid <= 0, in_ready=1 that cycle. park_r contents are don't-care.
- Reset (reset=0):
  - All parked bits <= 0, out_valid <= 0, out_mask <= 0, out_result <= 0.
  - in_ready reads 0 during reset; lane_parked=0.
- Reset and flush mid-wait both discard any partially parked group. No result for that group is ever emitted.
- Simultaneous events:
  - A lane completing in the same cycle as go is taken live and not parked.
  - ws_ready=1 together with go loads the new group in the same edge, giving back-to-back transfers.

Optional Feature:
- Macro: EXM_LANE_SYNC_PERF_EN.
- Defined: adds output perf_wait_cycles (32-bit) and input perf_clr (1-bit).
  - Counter increments each cycle where |lane_valid & !go & !flush.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset or perf_clr; perf_clr wins over increment.
- Undefined: neither port exists, and there is no counter logic.

Test Plan:
1. LANES=2; lane_valid=2'b11, lane_ok=2'b11, results 32'h11/32'h22, ws_ready=1 -> in_ready=1 same cycle; next cycle out_valid=1, out_mask=2'b11, out_result={32'h22,32'h11}.
2. Lane0 ok in cycle 0 (32'hAAAA), lane1 ok in cycle 3 (32'hBBBB), lane0 result driven to garbage after cycle 0:
   - lane_parked=2'b01 from cycle 1 to cycle 3.
   - in_ready=1 in cycle 3; out_result={32'hBBBB,32'hAAAA} in cycle 4.
   - With EXM_LANE_SYNC_PERF_EN, perf_wait_cycles=3.
3. Both lanes ok with out_valid=1 and ws_ready=0 for 2 cycles:
   - lanes park, in_ready=0, and the old out_* are held.
   - On ws_ready=1, in_ready=1 and the new group appears the next cycle.
4. Lane0 parked, flush=1 in cycle 2 -> lane_parked=0 and out_valid=0 next cycle; the group is never emitted and in_ready=1 during the flush cycle.
5. lane_valid=2'b10 (lane0 empty) with lane1 ok -> out_mask=2'b10. lane_valid=2'b00 -> in_ready=1, out_valid stays 0.
6. reset=0 asserted while lane1 parked and out_valid=1 -> after the edge all outputs are 0. Group fires normally once reset=1.
